csel_addsub_seq: RTL and testbench



---
 rtl/csel_addsub_if.sv | 44 ++++
 rtl/csel_addsub_seq.sv | 136 +++++++++++++
 tb/tb_csel_addsub_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/csel_addsub_if.sv
// csel_addsub_if: operand/result stream bundle for the iterative add/sub unit.
//   slave  modport (unit side):     in_valid, a, b, sub, out_ready in;
//                                   in_ready, out_valid, result, cout, ovf out.
//   master modport (producer side): the mirror image.
interface csel_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output cout,
        output ovf
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  cout,
        input  ovf
    );
endinterface

// File: rtl/csel_addsub_seq.sv
// csel_addsub_seq: iterative add/subtract unit. One NIB-bit carry-select slice is reused over
// WIDTH/NIB cycles; each cycle both carry-in variants of the slice sum are formed and the
// registered carry picks one. Subtraction is a + ~b + 1 (b inverted at latch, carry seeded 1).
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : csel_addsub_if slave modport
//          in_valid/in_ready/a/b/sub   operand handshake
//          out_valid/out_ready         result handshake
//          result/cout/ovf             sum or difference, carry (1 = no borrow on sub),
//                                      signed overflow; only meaningful while out_valid
module csel_addsub_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NIB   = 4
) (
    input  logic               clk,
    input  logic               rst,
    csel_addsub_if.slave       bus
);

    localparam int unsigned NSLICE = WIDTH / NIB;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % NIB) != 0 || NIB == 0) begin : g_bad_params
            $error("csel_addsub_seq: WIDTH must be a non-zero multiple of NIB");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    // Holds the effective B operand: already inverted for subtraction.
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Carry-select slice datapath.
    logic [31:0]      slice_base;
    logic [NIB-1:0]   a_nib;
    logic [NIB-1:0]   b_nib;
    logic [NIB:0]     sum0;
    logic [NIB:0]     sum1;
    logic [NIB:0]     sum_sel;

    always_comb begin
        slice_base = 32'(idx_q) * NIB;
        a_nib      = a_q[slice_base +: NIB];
        b_nib      = b_q[slice_base +: NIB];
        sum0       = {1'b0, a_nib} + {1'b0, b_nib};
        sum1       = {1'b0, a_nib} + {1'b0, b_nib} + (NIB + 1)'(1);
        sum_sel    = carry_q ? sum1 : sum0;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    idx_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                result_d[slice_base +: NIB] = sum_sel[NIB-1:0];
                carry_d = sum_sel[NIB];
                if (idx_q == LAST_IDX) begin
                    cout_d  = sum_sel[NIB];
                    // result_d already holds the new MSB since the last slice owns it.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (result_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // in_ready is held low while reset is asserted so nothing is offered during reset.
    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_csel_addsub_seq.sv
module tb_csel_addsub_seq;

    localparam int N_RAND = 300;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    csel_addsub_if #(.WIDTH(16)) bus ();

    csel_addsub_seq #(
        .WIDTH(16),
        .NIB  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
        bus.a        = ta;
        bus.b        = tb;
        bus.sub      = ts;
        bus.in_valid = 1'b1;
    endtask

    // Called #1 after the acceptance edge: waits for the result, checks it and the latency,
    // then completes the output handshake.
    task automatic finish_op(input string tag, input logic [15:0] er, input logic ec,
                             input logic eo);
        int n;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check_val({tag, "_lat"}, 32'(n), 32'd4);
        check_val({tag, "_res"}, 32'({bus.result, bus.cout, bus.ovf}), 32'({er, ec, eo}));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val({tag, "_hs"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic ts, input logic [15:0] er, input logic ec, input logic eo);
        issue(ta, tb, ts);
        check_val({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        step();
        finish_op(tag, er, ec, eo);
    endtask

    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic ms);
        int          sa;
        int          sb;
        int          sr;
        logic [15:0] r;
        logic        c;
        logic        o;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        sr = ms ? (sa - sb) : (sa + sb);
        o  = (sr > 32767) || (sr < -32768);
        r  = ms ? (ma - mb) : (ma + mb);
        if (ms) c = (ma >= mb);
        else    c = (32'(ma) + 32'(mb)) > 32'hFFFF;
        return {r, c, o};
    endfunction

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check_val("reset_state",
                  32'({bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.ovf}),
                  32'({1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}));

        // Reset two cycles into a calculation.
        issue(16'h1234, 16'h0001, 1'b0);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check_val("midrst_async", 32'({bus.out_valid, bus.result}), 32'({1'b0, 16'h0000}));
        step();
        rst = 1'b0;
        #1;
        check_val("midrst_release",
                  32'({bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.ovf}),
                  32'({1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}));
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("midrst_idle", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        end
        run_op("post_rst", 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0);

        // Directed vectors.
        run_op("sub_basic",  16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1, 1'b0);
        run_op("sub_borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("add_chain",  16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("sub_equal",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("add_nib",    16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Backpressure: result held while new operands are offered and refused.
        issue(16'h1111, 16'h2222, 1'b0);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_val("bp_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            issue(16'(16'h0101 * (i + 1)), 16'(16'h1010 * (i + 3)), 1'(i % 2));
            step();
            check_val("bp_hold", 32'({bus.result, bus.cout, bus.ovf}),
                      32'({16'h3333, 1'b0, 1'b0}));
            check_val("bp_flags", 32'({bus.out_valid, bus.in_ready}), 32'b10);
        end
        issue(16'h0002, 16'h0003, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val("bp_release", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        step();
        finish_op("bp_next", 16'h0005, 1'b0, 1'b0);

        // Random stream with random valid/ready against the reference model.
        begin
            logic [17:0] exp_q[$];
            int          issued;
            int          done;
            int          cyc;
            issued = 0;
            done   = 0;
            cyc    = 0;
            while (done < N_RAND && cyc < 30000) begin
                bus.in_valid  = (issued < N_RAND) && ($urandom_range(0, 3) != 0);
                bus.a         = 16'($urandom);
                bus.b         = 16'($urandom);
                bus.sub       = 1'($urandom_range(0, 1));
                bus.out_ready = ($urandom_range(0, 2) != 0);
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model(bus.a, bus.b, bus.sub));
                    issued++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("rand_spurious", 32'(done), 32'(issued + 1));
                    end else begin
                        check_val("rand_op", 32'({bus.result, bus.cout, bus.ovf}),
                                  32'(exp_q.pop_front()));
                    end
                    done++;
                end
                step();
                cyc++;
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            check_val("rand_count", 32'(done), 32'(N_RAND));
            check_val("rand_issued", 32'(issued), 32'(N_RAND));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
